bsearch_init: RTL and testbench

Sequential binary-search initiator that drives 8-bit probe operands toward a magnitude comparator and consumes its 2-bit compare code (2 = probe greater, 1 = probe less, 0 = equal). It finds an unknown value held on the comparator's other operand in at most WIDTH+1 probes. It sits upstream of the comparator: `guess` drives its first operand, and `cmp_code` is taken from the low two bits of its result.

---
 rtl/bsearch_init.sv | 165 ++++++++++++++++
 tb/tb_bsearch_init.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bsearch_init.sv
// Binary-search probe generator for an external magnitude comparator.
// Optional WAIT timeout is compiled in with `define BSEARCH_TIMEOUT_EN.
module bsearch_init #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  output logic             guess_valid,
  input  logic [1:0]       cmp_code,
  input  logic             cmp_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] found,
  output logic [4:0]       steps
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = 1;

  state_t           state;
  state_t           nstate;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] nlo;
  logic [WIDTH-1:0] nhi;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mid;
  logic             hit;
  logic             fail;
  logic             tmo;

`ifdef BSEARCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == ISSUE) begin
      tcnt <= '0;
    end else if (state == WAIT && !cmp_valid) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // A response in the expiring cycle wins over the timeout.
  assign tmo = (state == WAIT) && !cmp_valid &&
               (tcnt == TW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0 & (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    nlo    = lo;
    nhi    = hi;
    hit    = 1'b0;
    fail   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nstate = ISSUE;
          nlo    = '0;
          nhi    = '1;
        end
      end
      ISSUE: nstate = WAIT;
      WAIT: begin
        if (cmp_valid) begin
          unique case (cmp_code)
            2'd0: begin
              hit    = 1'b1;
              nstate = DONE;
            end
            2'd2: begin
              if (guess == lo) begin
                fail = 1'b1;
              end else begin
                nhi    = guess - ONE;
                nstate = ISSUE;
              end
            end
            2'd1: begin
              if (guess == hi) begin
                fail = 1'b1;
              end else begin
                nlo    = guess + ONE;
                nstate = ISSUE;
              end
            end
            default: fail = 1'b1;
          endcase
        end else if (tmo) begin
          fail = 1'b1;
        end
        if (fail) begin
          nstate = DONE;
        end
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Midpoint of the bounds about to take effect, one bit wider.
  assign sum = {1'b0, nlo} + {1'b0, nhi};
  assign mid = WIDTH'(sum >> 1);

  always_comb begin
    guess_valid = (state == ISSUE);
    busy        = (state == ISSUE) || (state == WAIT);
    done        = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo    <= '0;
      hi    <= '1;
      guess <= '0;
      found <= '0;
      err   <= 1'b0;
      steps <= '0;
    end else begin
      lo <= nlo;
      hi <= nhi;
      if (nstate == ISSUE) begin
        guess <= mid;
      end
      if (state == IDLE && start) begin
        found <= '0;
        err   <= 1'b0;
        steps <= '0;
      end
      if (state == ISSUE) begin
        steps <= steps + 5'd1;
      end
      if (hit) begin
        found <= guess;
      end
      if (fail) begin
        err   <= 1'b1;
        found <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bsearch_init.sv
// Directed bench for bsearch_init: searches, error paths, reset abort,
// and the WAIT timeout in both build flavours.
module tb_bsearch_init;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] guess;
  logic       guess_valid;
  logic [1:0] cmp_code;
  logic       cmp_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] found;
  logic [4:0] steps;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] probes [0:15];
  int nprobe;
  int cyc;

  always #5 clk = ~clk;

  bsearch_init #(.WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .guess(guess),
    .guess_valid(guess_valid),
    .cmp_code(cmp_code),
    .cmp_valid(cmp_valid),
    .busy(busy),
    .done(done),
    .err(err),
    .found(found),
    .steps(steps)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // mode 0: honest, 1: code 3 on 2nd probe, 2: always 2,
  // 3: honest while start held high the whole search
  task automatic search(input logic [7:0] tgt, input int mode);
    nprobe = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (mode != 3) start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (guess_valid) begin
        probes[nprobe] = guess;
        nprobe++;
      end
      cmp_valid = busy && !guess_valid;
      if (mode == 2) cmp_code = 2'd2;
      else if (mode == 1 && nprobe == 2) cmp_code = 2'd3;
      else if (guess > tgt) cmp_code = 2'd2;
      else if (guess < tgt) cmp_code = 2'd1;
      else cmp_code = 2'd0;
      @(posedge clk); #1;
      cyc++;
    end
    cmp_valid = 1'b0;
    check("search_done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] exp_p [0:7];
    int w;
    exp_p = '{8'h7F, 8'h3F, 8'h5F, 8'h4F,
              8'h57, 8'h5B, 8'h59, 8'h5A};
    rst = 1'b1;
    start = 1'b0;
    cmp_valid = 1'b0;
    cmp_code = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_guess", {24'd0, guess}, 32'h0);
    check("rst_gv", {31'd0, guess_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_found", {24'd0, found}, 32'h0);
    check("rst_steps", {27'd0, steps}, 32'd0);

    search(8'h5A, 0);
    check("5a_err", {31'd0, err}, 32'd0);
    check("5a_found", {24'd0, found}, 32'h5A);
    check("5a_steps", {27'd0, steps}, 32'd8);
    check("5a_cycles", cyc, 32'd17);
    check("5a_nprobe", nprobe, 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("5a_probe%0d", i), {24'd0, probes[i]},
            {24'd0, exp_p[i]});
    @(posedge clk); #1;
    check("5a_idle", {31'd0, done | busy}, 32'd0);
    check("5a_found_hold", {24'd0, found}, 32'h5A);

    search(8'h00, 0);
    check("00_err", {31'd0, err}, 32'd0);
    check("00_found", {24'd0, found}, 32'h00);
    check("00_steps", {27'd0, steps}, 32'd8);
    @(posedge clk); #1;

    search(8'hFF, 0);
    check("ff_err", {31'd0, err}, 32'd0);
    check("ff_found", {24'd0, found}, 32'hFF);
    check("ff_steps", {27'd0, steps}, 32'd9);
    check("ff_cycles", cyc, 32'd19);
    @(posedge clk); #1;

    search(8'h10, 1);
    check("c3_err", {31'd0, err}, 32'd1);
    check("c3_found", {24'd0, found}, 32'h0);
    check("c3_steps", {27'd0, steps}, 32'd2);
    @(posedge clk); #1;

    search(8'h10, 2);
    check("inc_err", {31'd0, err}, 32'd1);
    check("inc_found", {24'd0, found}, 32'h0);
    check("inc_steps", {27'd0, steps}, 32'd8);
    check("inc_last", {24'd0, probes[7]}, 32'h0);
    @(posedge clk); #1;

    // start held through the search and into DONE must be ignored
    search(8'h5A, 3);
    check("hold_found", {24'd0, found}, 32'h5A);
    check("hold_steps", {27'd0, steps}, 32'd8);
    check("hold_cycles", cyc, 32'd17);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_no_restart", {31'd0, busy}, 32'd0);

    // reset while waiting
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rw_in_wait", {31'd0, busy & ~guess_valid}, 32'd1);
    rst = 1'b1;
    cmp_valid = 1'b1;
    cmp_code = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_valid = 1'b0;
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_gv", {31'd0, guess_valid}, 32'd0);
    check("rw_done", {31'd0, done}, 32'd0);
    check("rw_guess", {24'd0, guess}, 32'h0);
    check("rw_found", {24'd0, found}, 32'h0);
    check("rw_steps", {27'd0, steps}, 32'd0);
    @(posedge clk); #1;
    check("rw_stay_idle", {31'd0, busy | done}, 32'd0);

    search(8'h33, 0);
    check("33_err", {31'd0, err}, 32'd0);
    check("33_found", {24'd0, found}, 32'h33);
    check("33_steps", {27'd0, steps}, 32'd6);
    check("33_cycles", cyc, 32'd13);
    @(posedge clk); #1;

    // silent responder
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    w = 0;
    while (!done && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
`ifdef BSEARCH_TIMEOUT_EN
    check("tmo_cycles", w, 32'd15);
    check("tmo_done", {31'd0, done}, 32'd1);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_found", {24'd0, found}, 32'h0);
    check("tmo_steps", {27'd0, steps}, 32'd1);
`else
    check("notmo_done", {31'd0, done}, 32'd0);
    check("notmo_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("notmo_rst", {31'd0, busy}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
